// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared sizes and FSM state type for the negacyclic NTT engine
package ntt_pkg;
  localparam int D_WIDTH   = 32;
  localparam int BN        = 16;
  localparam int MA        = 16;
  localparam int DEGREE    = BN * MA;
  localparam int LOGN      = $clog2(DEGREE);
  localparam int K         = 2;
  localparam int BW        = $clog2(BN);
  localparam int LW        = $clog2(LOGN);
  localparam int TF_ROWS   = K + 3;
  localparam int TF_COLS   = 15;
  localparam int TF_CONSTS = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_TW,
    S_BF,
    S_DN
  } state_t;
endpackage

// File: rtl/ntt_mem.sv
// rtl/ntt_mem.sv - banked coefficient store, two combinational reads, two clocked writes
module ntt_mem
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic [LOGN-1:0]    i_rd0_addr,
  input  logic [LOGN-1:0]    i_rd1_addr,
  output logic [D_WIDTH-1:0] o_rd0_data,
  output logic [D_WIDTH-1:0] o_rd1_data,
  input  logic               i_we,
  input  logic [LOGN-1:0]    i_wr0_addr,
  input  logic [LOGN-1:0]    i_wr1_addr,
  input  logic [D_WIDTH-1:0] i_wr0_data,
  input  logic [D_WIDTH-1:0] i_wr1_data
);
  // coefficient n lives in bank n % BN, word n / BN
  logic [D_WIDTH-1:0] memory_array [BN][MA];

  assign o_rd0_data = memory_array[i_rd0_addr[BW-1:0]][i_rd0_addr[LOGN-1:BW]];
  assign o_rd1_data = memory_array[i_rd1_addr[BW-1:0]][i_rd1_addr[LOGN-1:BW]];

  always_ff @(posedge clk) begin
    if (i_we) begin
      memory_array[i_wr0_addr[BW-1:0]][i_wr0_addr[LOGN-1:BW]] <= i_wr0_data;
      memory_array[i_wr1_addr[BW-1:0]][i_wr1_addr[LOGN-1:BW]] <= i_wr1_data;
    end
  end
endmodule

// File: rtl/ntt_mem_top.sv
// rtl/ntt_mem_top.sv - memory wrapper holding the coefficient store instance
module ntt_mem_top
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic [LOGN-1:0]    i_rd0_addr,
  input  logic [LOGN-1:0]    i_rd1_addr,
  output logic [D_WIDTH-1:0] o_rd0_data,
  output logic [D_WIDTH-1:0] o_rd1_data,
  input  logic               i_we,
  input  logic [LOGN-1:0]    i_wr0_addr,
  input  logic [LOGN-1:0]    i_wr1_addr,
  input  logic [D_WIDTH-1:0] i_wr0_data,
  input  logic [D_WIDTH-1:0] i_wr1_data
);
  ntt_mem memory_rtl (
    .clk        (clk),
    .i_rd0_addr (i_rd0_addr),
    .i_rd1_addr (i_rd1_addr),
    .o_rd0_data (o_rd0_data),
    .o_rd1_data (o_rd1_data),
    .i_we       (i_we),
    .i_wr0_addr (i_wr0_addr),
    .i_wr1_addr (i_wr1_addr),
    .i_wr0_data (i_wr0_data),
    .i_wr1_data (i_wr1_data)
  );
endmodule

// File: rtl/ntt_mod_mul.sv
// rtl/ntt_mod_mul.sv - full-width modular multiply, a*b mod q
module ntt_mod_mul
  import ntt_pkg::*;
(
  input  logic [D_WIDTH-1:0] i_a,
  input  logic [D_WIDTH-1:0] i_b,
  input  logic [D_WIDTH-1:0] i_q,
  output logic [D_WIDTH-1:0] o_p
);
  logic [2*D_WIDTH-1:0] w_prod;

  assign w_prod = {{D_WIDTH{1'b0}}, i_a} * {{D_WIDTH{1'b0}}, i_b};
  assign o_p    = D_WIDTH'(w_prod % {{D_WIDTH{1'b0}}, i_q});
endmodule

// File: rtl/ntt_tf_gen.sv
// rtl/ntt_tf_gen.sv - twiddle storage: base/const arrays, psi power table P and accumulator S
module ntt_tf_gen
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               i_cfg_we,
  input  logic               i_cfg_const,
  input  logic [3:0]         i_cfg_row,
  input  logic [3:0]         i_cfg_col,
  input  logic [D_WIDTH-1:0] i_cfg_data,
  input  logic               i_p_we,
  input  logic [LW-1:0]      i_p_wr_idx,
  input  logic [D_WIDTH-1:0] i_p_wr_data,
  input  logic [LW-1:0]      i_p_rd_idx,
  input  logic               i_s_init,
  input  logic               i_s_we,
  input  logic [D_WIDTH-1:0] i_s_wr_data,
  output logic [D_WIDTH-1:0] o_psi,
  output logic [D_WIDTH-1:0] o_p,
  output logic [D_WIDTH-1:0] o_s
);
  logic [D_WIDTH-1:0] TF_base_array  [TF_ROWS][TF_COLS];
  logic [D_WIDTH-1:0] TF_const_array [TF_CONSTS];
  logic [D_WIDTH-1:0] r_p [LOGN];
  logic [D_WIDTH-1:0] r_s;

  assign o_psi = TF_base_array[0][0];
  assign o_p   = r_p[i_p_rd_idx];
  assign o_s   = r_s;

  // seed arrays are never cleared; they hold unless rewritten
  always_ff @(posedge clk) begin
    for (int r = 0; r < TF_ROWS; r++) begin
      for (int c = 0; c < TF_COLS; c++) begin
        TF_base_array[r][c] <= (i_cfg_we && !i_cfg_const && int'(i_cfg_row) == r && int'(i_cfg_col) == c)
                               ? i_cfg_data : TF_base_array[r][c];
      end
    end
    for (int c = 0; c < TF_CONSTS; c++) begin
      TF_const_array[c] <= (i_cfg_we && i_cfg_const && int'(i_cfg_col) == c) ? i_cfg_data : TF_const_array[c];
    end
  end

  always_ff @(posedge clk) begin
    if (i_p_we) begin
      r_p[i_p_wr_idx] <= i_p_wr_data;
    end
    if (i_s_init) begin
      r_s <= D_WIDTH'(1);
    end else if (i_s_we) begin
      r_s <= i_s_wr_data;
    end
  end
endmodule

// File: rtl/ntt_tf_top.sv
// rtl/ntt_tf_top.sv - twiddle wrapper holding the twiddle generator instance
module ntt_tf_top
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               i_cfg_we,
  input  logic               i_cfg_const,
  input  logic [3:0]         i_cfg_row,
  input  logic [3:0]         i_cfg_col,
  input  logic [D_WIDTH-1:0] i_cfg_data,
  input  logic               i_p_we,
  input  logic [LW-1:0]      i_p_wr_idx,
  input  logic [D_WIDTH-1:0] i_p_wr_data,
  input  logic [LW-1:0]      i_p_rd_idx,
  input  logic               i_s_init,
  input  logic               i_s_we,
  input  logic [D_WIDTH-1:0] i_s_wr_data,
  output logic [D_WIDTH-1:0] o_psi,
  output logic [D_WIDTH-1:0] o_p,
  output logic [D_WIDTH-1:0] o_s
);
  ntt_tf_gen TF_gen (
    .clk         (clk),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_const (i_cfg_const),
    .i_cfg_row   (i_cfg_row),
    .i_cfg_col   (i_cfg_col),
    .i_cfg_data  (i_cfg_data),
    .i_p_we      (i_p_we),
    .i_p_wr_idx  (i_p_wr_idx),
    .i_p_wr_data (i_p_wr_data),
    .i_p_rd_idx  (i_p_rd_idx),
    .i_s_init    (i_s_init),
    .i_s_we      (i_s_we),
    .i_s_wr_data (i_s_wr_data),
    .o_psi       (o_psi),
    .o_p         (o_p),
    .o_s         (o_s)
  );
endmodule

// File: rtl/ntt_top.sv
// rtl/ntt_top.sv - in-place negacyclic Cooley-Tukey NTT over the banked coefficient store
module ntt_top
  import ntt_pkg::*;
#(
  parameter int START_DELAY = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] modulus,
  output logic               DONE
);
  localparam int CW = ($clog2(START_DELAY) > LOGN) ? $clog2(START_DELAY) + 1 : LOGN + 1;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [LW-1:0]      r_stage;
  logic [LOGN-1:0]    r_i, r_k;
  logic               r_done;
  logic [LOGN-1:0]    w_m, w_t, w_g, w_j, w_jt;
  logic               w_cnt_last, w_k_last, w_i_last, w_last_stage, w_tw_bit;
  logic               w_p_we, w_s_init, w_s_we, w_mem_we;
  logic [LW-1:0]      w_p_rd_idx;
  logic [D_WIDTH-1:0] w_mul_a, w_mul_b, w_prod, w_p_wr_data;
  logic [D_WIDTH-1:0] w_psi, w_p, w_s, w_u, w_v_in, w_add_res, w_sub_res;
  logic [D_WIDTH:0]   w_sum, w_dif;

  // group index g = m + i walks 1..N-1 in order, so brev(g) drives the twiddle
  assign w_m          = LOGN'(1) << r_stage;
  assign w_t          = LOGN'(DEGREE / 2) >> r_stage;
  assign w_g          = w_m + r_i;
  assign w_j          = ((r_i * w_t) << 1) + r_k;
  assign w_jt         = w_j + w_t;
  assign w_tw_bit     = w_g[LW'(LOGN - 1) - r_cnt[LW-1:0]];
  assign w_last_stage = (r_stage == LW'(LOGN - 1));
  assign w_i_last     = (r_i == w_m - LOGN'(1));
  assign w_k_last     = (r_k == w_t - LOGN'(1));
  assign w_cnt_last   = (r_state == S_IDLE) ? (r_cnt == CW'(START_DELAY - 1)) : (r_cnt == CW'(LOGN - 1));

  assign w_p_rd_idx  = (r_state == S_PRE) ? r_cnt[LW-1:0] - LW'(1) : r_cnt[LW-1:0];
  assign w_mul_a     = (r_state == S_BF) ? w_v_in : (r_state == S_TW) ? w_s : w_p;
  assign w_mul_b     = (r_state == S_BF) ? w_s : w_p;
  assign w_p_wr_data = (r_cnt == '0) ? w_psi : w_prod;

  assign w_sum     = {1'b0, w_u} + {1'b0, w_prod};
  assign w_dif     = {1'b0, w_u} + {1'b0, modulus} - {1'b0, w_prod};
  assign w_add_res = (w_sum >= {1'b0, modulus}) ? w_sum[D_WIDTH-1:0] - modulus : w_sum[D_WIDTH-1:0];
  assign w_sub_res = (w_dif >= {1'b0, modulus}) ? w_dif[D_WIDTH-1:0] - modulus : w_dif[D_WIDTH-1:0];
  assign DONE      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_p_we   = 1'b0;
    w_s_init = 1'b0;
    w_s_we   = 1'b0;
    w_mem_we = 1'b0;
    case (r_state)
      S_IDLE: if (w_cnt_last) w_next = S_PRE;
      S_PRE: begin
        w_p_we = 1'b1;
        if (w_cnt_last) begin
          w_next   = S_TW;
          w_s_init = 1'b1;
        end
      end
      S_TW: begin
        w_s_we = w_tw_bit;
        if (w_cnt_last) w_next = S_BF;
      end
      S_BF: begin
        w_mem_we = 1'b1;
        if (w_k_last) begin
          if (w_i_last && w_last_stage) begin
            w_next = S_DN;
          end else begin
            w_next   = S_TW;
            w_s_init = 1'b1;
          end
        end
      end
      S_DN: w_next = S_DN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_stage <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_PRE, S_TW: r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
        S_BF: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_i_last) begin
              r_i     <= '0;
              r_stage <= r_stage + LW'(1);
            end else begin
              r_i <= r_i + LOGN'(1);
            end
          end else begin
            r_k <= r_k + LOGN'(1);
          end
        end
        S_DN: r_done <= 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  ntt_mod_mul u_mod_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .i_q (modulus),
    .o_p (w_prod)
  );

  ntt_mem_top memory_top (
    .clk        (clk),
    .i_rd0_addr (w_j),
    .i_rd1_addr (w_jt),
    .o_rd0_data (w_u),
    .o_rd1_data (w_v_in),
    .i_we       (w_mem_we),
    .i_wr0_addr (w_j),
    .i_wr1_addr (w_jt),
    .i_wr0_data (w_add_res),
    .i_wr1_data (w_sub_res)
  );

  ntt_tf_top TF_top (
    .clk         (clk),
    .i_cfg_we    (1'b0),
    .i_cfg_const (1'b0),
    .i_cfg_row   (4'd0),
    .i_cfg_col   (4'd0),
    .i_cfg_data  ({D_WIDTH{1'b0}}),
    .i_p_we      (w_p_we),
    .i_p_wr_idx  (r_cnt[LW-1:0]),
    .i_p_wr_data (w_p_wr_data),
    .i_p_rd_idx  (w_p_rd_idx),
    .i_s_init    (w_s_init),
    .i_s_we      (w_s_we),
    .i_s_wr_data (w_prod),
    .o_psi       (w_psi),
    .o_p         (w_p),
    .o_s         (w_s)
  );
endmodule

// File: tb/tb_ntt_top.sv
// tb/tb_ntt_top.sv - directed and randomized checks of ntt_top against a software NTT
module tb_ntt_top;
  import ntt_pkg::*;

  localparam int N      = DEGREE;
  localparam int T_DONE = 3137;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] modulus = 32'd65537;
  logic        DONE;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned q = 65537;
  longint unsigned psi;
  longint unsigned stim [N];
  longint unsigned expv [N];

  ntt_top #(.START_DELAY(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .modulus (modulus),
    .DONE    (DONE)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned pw(input longint unsigned base, input longint unsigned e);
    longint unsigned r = 1;
    longint unsigned b = base % q;
    while (e != 0) begin
      if (e[0]) r = (r * b) % q;
      b = (b * b) % q;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < LOGN; b++) if ((x >> b) & 1) r = r | (1 << (LOGN - 1 - b));
    return r;
  endfunction

  function automatic longint unsigned find_psi();
    for (longint unsigned g = 2; g < q; g++)
      if (pw(g, (q - 1) / 2) == q - 1) return pw(g, (q - 1) / (2 * N));
    return 0;
  endfunction

  function automatic void ref_ntt();
    longint unsigned a [N];
    longint unsigned s, u, v;
    int t;
    a = stim;
    for (int m = 1; m < N; m = m * 2) begin
      t = N / (2 * m);
      for (int i = 0; i < m; i++) begin
        s = pw(psi, longint'(brev(m + i)));
        for (int j = 2 * i * t; j < 2 * i * t + t; j++) begin
          u = a[j];
          v = (a[j + t] * s) % q;
          a[j]     = (u + v) % q;
          a[j + t] = (u + q - v) % q;
        end
      end
    end
    expv = a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_reset_done"}, {63'b0, DONE}, 64'd0);
    rst = 1'b0;
    for (int n = 0; n < N; n++) dut.memory_top.memory_rtl.memory_array[n % BN][n / BN] = stim[n][31:0];
    dut.TF_top.TF_gen.TF_base_array[0][0] = psi[31:0];
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, 64'(n), 64'(T_DONE));
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s[%0d]", tag, k), {32'b0, dut.memory_top.memory_rtl.memory_array[k % BN][k / BN]}, expv[k]);
  endtask

  task automatic hold_check(input string tag, input int cycles);
    logic stuck = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (DONE !== 1'b1) stuck = 1'b0;
    end
    chk(tag, {63'b0, stuck}, 64'd1);
  endtask

  initial begin
    psi = pw(3, 128);
    chk("psi_order", pw(psi, N), q - 1);

    // delta input transforms to all ones
    for (int n = 0; n < N; n++) begin stim[n] = 0; expv[n] = 1; end
    stim[0] = 1;
    start_run("delta");
    wait_done("delta");
    check_mem("delta");

    for (int n = 0; n < N; n++) begin stim[n] = 0; expv[n] = 0; end
    start_run("zero");
    wait_done("zero");
    check_mem("zero");

    // x^1 evaluates to psi^(2*brev(k)+1) at output position k
    for (int n = 0; n < N; n++) begin stim[n] = 0; expv[n] = pw(psi, longint'(2 * brev(n) + 1)); end
    stim[1] = 1;
    start_run("x1");
    wait_done("x1");
    check_mem("x1");

    for (int n = 0; n < N; n++) stim[n] = longint'($urandom % 32'd65537);
    ref_ntt();
    start_run("rand");
    wait_done("rand");
    check_mem("rand");
    hold_check("rand_done_sticky", 1000);
    check_mem("rand_hold");

    q = 12289;
    modulus = 32'd12289;
    psi = find_psi();
    for (int n = 0; n < N; n++) stim[n] = longint'($urandom % 32'd12289);
    ref_ntt();
    start_run("rand_q2");
    wait_done("rand_q2");
    check_mem("rand_q2");

    // reset mid-computation restarts from idle on the partial memory
    start_run("midrst");
    repeat (1500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_done_low", {63'b0, DONE}, 64'd0);
    rst = 1'b0;
    wait_done("midrst_restart");
    hold_check("midrst_done_sticky", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
